// File: rtl/spike_encoder_pkg.sv
// Shared types and constants for the spike encoder.
//   state_t            - encoder FSM states
//   LFSR_W             - width of the pseudo-random source
//   LFSR_TAPS          - Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   LFSR_SEED_DEFAULT  - non-zero reset value of the LFSR
//   lfsr_next()        - one right-shifting Galois step
package spike_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int                LFSR_W            = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

    // Bit 0 shifts out and, when set, folds back into the tap positions.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Handshake bundle between upstream pixel source, spike encoder and network.
//   pix_valid/pix_data/pix_ready   - intensity vector handshake
//   net_ready/start                - network launch handshake
//   sample/sample_ready/in_spikes  - per-step spike transfer
//   done                           - end-of-sample pulse
// master: upstream + network side; slave: the encoder.
interface spike_encoder_if #(
    parameter int N_INPUTS = 4,
    parameter int PIXEL_W  = 8
);
    logic                         pix_valid;
    logic [N_INPUTS*PIXEL_W-1:0]  pix_data;
    logic                         pix_ready;
    logic                         net_ready;
    logic                         start;
    logic                         sample;
    logic                         sample_ready;
    logic [N_INPUTS-1:0]          in_spikes;
    logic                         done;

    modport master (
        output pix_valid, pix_data, net_ready, sample,
        input  pix_ready, start, sample_ready, in_spikes, done
    );

    modport slave (
        input  pix_valid, pix_data, net_ready, sample,
        output pix_ready, start, sample_ready, in_spikes, done
    );
endinterface

// File: rtl/spike_lfsr.sv
// 32-bit Galois LFSR used as the random source for rate coding.
//   clk        - clock
//   load_seed  - synchronous load of SEED (takes priority over en)
//   en         - advance one step
//   state      - current LFSR contents
module spike_lfsr
    import spike_encoder_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              load_seed,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (load_seed) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: latches an intensity vector, launches the
// network and presents N_CYCLES steps of spikes, one per consumed sample.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - spike_encoder_if.slave (pixel, launch and spike handshakes)
// Build option: SPIKE_ENCODER_DETERMINISTIC_EN replaces the LFSR with a
// per-channel phase accumulator (spike on carry-out).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | pix_ready high, waiting for a vector
// ST_LOAD | vector latched, waiting for net_ready to pulse start
// ST_RUN  | presenting steps; first cycle generates step 1
// ST_DONE | done pulse, spikes cleared, returns to idle
module spike_encoder
    import spike_encoder_pkg::*;
#(
    parameter int                N_INPUTS            = 4,
    parameter int                PIXEL_W             = 8,
    parameter int                N_CYCLES            = 10,
    parameter int                CYCLES_CNT_BITWIDTH = 5,
    parameter logic [LFSR_W-1:0] LFSR_SEED           = LFSR_SEED_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    spike_encoder_if.slave bus
);

    localparam int DATA_W = N_INPUTS * PIXEL_W;
    localparam logic [CYCLES_CNT_BITWIDTH-1:0] LAST_STEP = CYCLES_CNT_BITWIDTH'(N_CYCLES);

    state_t                         state_q, state_d;
    logic                           pix_ready_q, pix_ready_d;
    logic                           start_q, start_d;
    logic                           sample_ready_q, sample_ready_d;
    logic [N_INPUTS-1:0]            in_spikes_q, in_spikes_d;
    logic                           done_q, done_d;
    logic [CYCLES_CNT_BITWIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [DATA_W-1:0]              pix_q;
    logic                           accept;
    logic                           gen_step;
    logic [N_INPUTS-1:0]            spike_gen;

`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_acc
        logic [PIXEL_W-1:0] pix_i;
        logic [PIXEL_W-1:0] acc_q;
        logic [PIXEL_W:0]   sum;

        assign pix_i        = pix_q[i*PIXEL_W +: PIXEL_W];
        assign sum          = {1'b0, acc_q} + {1'b0, pix_i};
        assign spike_gen[i] = sum[PIXEL_W] || (pix_i == '1);

        always_ff @(posedge clk) begin
            if (!rst_n || accept) begin
                acc_q <= '0;
            end else if (gen_step) begin
                acc_q <= sum[PIXEL_W-1:0];
            end
        end
    end
`else
    logic [LFSR_W-1:0] lfsr_state;

    // Reset reloads the seed; between samples the sequence just continues.
    spike_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .load_seed (!rst_n),
        .en        (gen_step),
        .state     (lfsr_state)
    );

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_cmp
        logic [PIXEL_W-1:0] pix_i;
        logic [PIXEL_W-1:0] rnd_i;

        assign pix_i        = pix_q[i*PIXEL_W +: PIXEL_W];
        assign rnd_i        = lfsr_state[i*PIXEL_W +: PIXEL_W];
        assign spike_gen[i] = (rnd_i < pix_i) || (pix_i == '1);
    end
`endif

    always_comb begin
        state_d        = state_q;
        pix_ready_d    = 1'b0;
        start_d        = 1'b0;
        sample_ready_d = 1'b0;
        in_spikes_d    = '0;
        done_d         = 1'b0;
        step_cnt_d     = step_cnt_q;
        accept         = 1'b0;
        gen_step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.pix_valid && pix_ready_q) begin
                    accept     = 1'b1;
                    step_cnt_d = '0;
                    state_d    = ST_LOAD;
                end else begin
                    pix_ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.net_ready) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sample_ready_d = 1'b1;
                in_spikes_d    = in_spikes_q;
                // Nothing presented yet (start cycle) or a step was consumed.
                if (!sample_ready_q || bus.sample) begin
                    if (sample_ready_q && (step_cnt_q == LAST_STEP)) begin
                        sample_ready_d = 1'b0;
                        in_spikes_d    = '0;
                        done_d         = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        gen_step    = 1'b1;
                        in_spikes_d = spike_gen;
                        step_cnt_d  = step_cnt_q + CYCLES_CNT_BITWIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                pix_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pix_ready_q    <= 1'b0;
            start_q        <= 1'b0;
            sample_ready_q <= 1'b0;
            in_spikes_q    <= '0;
            done_q         <= 1'b0;
            step_cnt_q     <= '0;
            pix_q          <= '0;
        end else begin
            state_q        <= state_d;
            pix_ready_q    <= pix_ready_d;
            start_q        <= start_d;
            sample_ready_q <= sample_ready_d;
            in_spikes_q    <= in_spikes_d;
            done_q         <= done_d;
            step_cnt_q     <= step_cnt_d;
            if (accept) begin
                pix_q <= bus.pix_data;
            end
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.start        = start_q;
    assign bus.sample_ready = sample_ready_q;
    assign bus.in_spikes    = in_spikes_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder. Expected spike vectors come from a
// bench-side encoder model and are queued on vector accept; a negedge monitor
// pops and compares them on every consumed step.
module tb_spike_encoder;

    localparam int          N_IN = 4;
    localparam int          PW   = 8;
    localparam int          NC   = 10;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spike_encoder_if #(.N_INPUTS(N_IN), .PIXEL_W(PW)) bus ();

    spike_encoder #(
        .N_INPUTS            (N_IN),
        .PIXEL_W             (PW),
        .N_CYCLES            (NC),
        .CYCLES_CNT_BITWIDTH (5),
        .LFSR_SEED           (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [N_IN-1:0] exp_q[$];
    logic [N_IN-1:0] mon_exp;

`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
    logic [PW-1:0] m_acc[N_IN];
`else
    logic [31:0] m_lfsr = SEED;

    // x^32 + x^22 + x^2 + x + 1, written out bit by bit.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] n;
        n     = s >> 1;
        n[31] = s[0];
        n[21] = s[22] ^ s[0];
        n[1]  = s[2] ^ s[0];
        n[0]  = s[1] ^ s[0];
        return n;
    endfunction
`endif

    task automatic model_reset;
`ifndef SPIKE_ENCODER_DETERMINISTIC_EN
        m_lfsr = SEED;
`endif
    endtask

    task automatic push_expected(input logic [31:0] pix);
        logic [N_IN-1:0] s;
        logic [PW-1:0]   p;
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
        logic [PW:0]     sum;
        for (int i = 0; i < N_IN; i++) m_acc[i] = '0;
`endif
        for (int k = 0; k < NC; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                p = pix[i*PW +: PW];
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
                sum      = {1'b0, m_acc[i]} + {1'b0, p};
                s[i]     = sum[PW] | (p == 8'hFF);
                m_acc[i] = sum[PW-1:0];
`else
                s[i] = (m_lfsr[i*PW +: PW] < p) | (p == 8'hFF);
`endif
            end
`ifndef SPIKE_ENCODER_DETERMINISTIC_EN
            m_lfsr = lfsr_adv(m_lfsr);
`endif
            exp_q.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.sample && bus.sample_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL spikes_unexpected: got %h, scoreboard empty", bus.in_spikes);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.in_spikes !== mon_exp)
                    $display("FAIL spikes: got %h want %h at %0t", bus.in_spikes, mon_exp, $time);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers a vector until accepted (bounded) and queues its expected steps.
    task automatic offer(input logic [31:0] pix, output bit ok);
        ok            = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix;
        for (int c = 0; c < 50; c++) begin
            if (bus.pix_ready === 1'b1) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
        bus.pix_valid = 1'b0;
        if (ok) push_expected(pix);
    endtask

    // Drives sample with the given period and records protocol observations
    // until done appears (left visible) or the cycle budget runs out.
    task automatic observe(input int period, input int max_cyc,
                           output int n_start, output int n_step, output int n_done,
                           output int n_gap, output int n_unstable);
        logic [N_IN-1:0] prev;
        bit              prev_valid;
        n_start = 0; n_step = 0; n_done = 0; n_gap = 0; n_unstable = 0;
        prev = '0; prev_valid = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            tick;
            if (bus.start === 1'b1) n_start++;
            if (bus.done === 1'b1) begin
                n_done++;
                break;
            end
            if (bus.sample_ready === 1'b1) begin
                if (prev_valid && bus.in_spikes !== prev) n_unstable++;
            end else if (n_step > 0) begin
                n_gap++;
            end
            bus.sample = ((c % period) == 0);
            if (bus.sample && bus.sample_ready === 1'b1) begin
                n_step++;
                prev_valid = 1'b0;
            end else if (bus.sample_ready === 1'b1) begin
                prev_valid = 1'b1;
                prev       = bus.in_spikes;
            end
        end
    endtask

    task automatic test_reset;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.net_ready = 1'b0; bus.sample = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick;
        n_checks++;
        if ({bus.pix_ready, bus.start, bus.sample_ready, bus.in_spikes, bus.done} !== 8'h00)
            $display("FAIL reset_outputs: got %b want 00000000",
                     {bus.pix_ready, bus.start, bus.sample_ready, bus.in_spikes, bus.done});
        else n_pass++;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (bus.pix_ready !== 1'b1) $display("FAIL reset_release_pix_ready: got %b want 1", bus.pix_ready);
        else n_pass++;
    endtask

    task automatic test_zero;
        bit ok; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        offer(32'h0000_0000, ok);
        n_checks++; if (!ok) $display("FAIL zero_accept: not accepted within budget"); else n_pass++;
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (ns != 1) $display("FAIL zero_start: got %0d pulses want 1", ns); else n_pass++;
        n_checks++; if (nst != NC) $display("FAIL zero_steps: got %0d want %0d", nst, NC); else n_pass++;
        n_checks++; if (nd != 1) $display("FAIL zero_done: got %0d want 1", nd); else n_pass++;
        tick;
        n_checks++;
        if ({bus.done, bus.pix_ready} !== 2'b01)
            $display("FAIL zero_done_width: got done,pix_ready=%b want 01", {bus.done, bus.pix_ready});
        else n_pass++;
    endtask

    task automatic test_full;
        bit ok; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        offer(32'hFFFF_FFFF, ok);
        n_checks++; if (!ok) $display("FAIL full_accept: not accepted within budget"); else n_pass++;
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (nst != NC) $display("FAIL full_steps: got %0d want %0d", nst, NC); else n_pass++;
        n_checks++; if (ng != 0) $display("FAIL full_bubbles: got %0d want 0", ng); else n_pass++;
        n_checks++; if (nd != 1) $display("FAIL full_done: got %0d want 1", nd); else n_pass++;
        tick;
    endtask

    task automatic test_patterns;
        bit ok; int ns, nst, nd, ng, nu;
        logic [31:0] pats[4];
        pats[0] = 32'h01FE_7F80;
        pats[1] = 32'hFF00_FF00;
        pats[2] = $urandom;
        pats[3] = $urandom;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        for (int v = 0; v < 4; v++) begin
            offer(pats[v], ok);
            observe(1, 60, ns, nst, nd, ng, nu);
            n_checks++;
            if (!ok || nst != NC || nd != 1 || ng != 0)
                $display("FAIL pattern_%0d: got ok=%0d steps=%0d done=%0d gaps=%0d want 1/%0d/1/0",
                         v, ok, nst, nd, ng, NC);
            else n_pass++;
        end
        tick;
    endtask

    task automatic test_net_wait;
        bit ok; int bad; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b0; bus.sample = 1'b1;
        offer(32'h4080_C0FF, ok);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus.start !== 1'b0 || bus.pix_ready !== 1'b0) bad++;
        end
        n_checks++; if (!ok || bad != 0) $display("FAIL net_wait_hold: got ok=%0d bad=%0d want 1/0", ok, bad); else n_pass++;
        bus.net_ready = 1'b1;
        tick;
        n_checks++; if (bus.start !== 1'b1) $display("FAIL net_wait_start: got %b want 1", bus.start); else n_pass++;
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (ns != 0) $display("FAIL net_wait_start_width: got %0d extra pulses want 0", ns); else n_pass++;
        n_checks++; if (nst != NC || nd != 1) $display("FAIL net_wait_run: got steps=%0d done=%0d want %0d/1", nst, nd, NC); else n_pass++;
        tick;
    endtask

    task automatic test_sample_toggle;
        bit ok; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b1; bus.sample = 1'b0;
        offer(32'h9C33_6AE0, ok);
        observe(3, 120, ns, nst, nd, ng, nu);
        n_checks++; if (nst != NC) $display("FAIL toggle_steps: got %0d want %0d", nst, NC); else n_pass++;
        n_checks++; if (nu != 0) $display("FAIL toggle_stable: got %0d changes want 0", nu); else n_pass++;
        n_checks++; if (ng != 0 || nd != 1) $display("FAIL toggle_done: got gaps=%0d done=%0d want 0/1", ng, nd); else n_pass++;
        bus.sample = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        bit ok; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        offer(32'h1234_5678, ok);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 32'hE0C0_A080;
        push_expected(32'hE0C0_A080);
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (nst != NC || nd != 1) $display("FAIL b2b_first: got steps=%0d done=%0d want %0d/1", nst, nd, NC); else n_pass++;
        tick;
        n_checks++; if (bus.pix_ready !== 1'b1) $display("FAIL b2b_idle_ready: got %b want 1", bus.pix_ready); else n_pass++;
        tick;
        n_checks++; if (bus.pix_ready !== 1'b0) $display("FAIL b2b_accept: got pix_ready %b want 0", bus.pix_ready); else n_pass++;
        bus.pix_valid = 1'b0;
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (nst != NC || nd != 1) $display("FAIL b2b_second: got steps=%0d done=%0d want %0d/1", nst, nd, NC); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid_run;
        bit ok; int cnt; int ns, nst, nd, ng, nu;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        offer(32'h7F7F_8181, ok);
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 5; c++) begin
            tick;
            if (bus.sample_ready === 1'b1) cnt++;
        end
        n_checks++; if (cnt != 5) $display("FAIL midrst_reach_step5: got %0d steps want 5", cnt); else n_pass++;
        rst_n = 1'b0;
        tick;
        n_checks++;
        if ({bus.pix_ready, bus.start, bus.sample_ready, bus.in_spikes, bus.done} !== 8'h00)
            $display("FAIL midrst_outputs: got %b want 00000000",
                     {bus.pix_ready, bus.start, bus.sample_ready, bus.in_spikes, bus.done});
        else n_pass++;
        exp_q.delete();
        model_reset();
        rst_n = 1'b1;
        tick;
        n_checks++; if (bus.pix_ready !== 1'b1) $display("FAIL midrst_release: got pix_ready %b want 1", bus.pix_ready); else n_pass++;
        offer(32'h55AA_33CC, ok);
        observe(1, 60, ns, nst, nd, ng, nu);
        n_checks++; if (!ok || nst != NC || nd != 1) $display("FAIL midrst_fresh: got ok=%0d steps=%0d done=%0d want 1/%0d/1", ok, nst, nd, NC); else n_pass++;
        tick;
    endtask

`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
    task automatic test_deterministic;
        bit ok; int n, nspk, seq_bad;
        bus.net_ready = 1'b1; bus.sample = 1'b1;
        offer(32'h8080_8080, ok);
        n = 0; nspk = 0; seq_bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (bus.done === 1'b1) break;
            if (bus.sample_ready === 1'b1) begin
                if (bus.in_spikes !== ((n % 2 == 1) ? 4'hF : 4'h0)) seq_bad++;
                if (bus.in_spikes === 4'hF) nspk++;
                n++;
            end
        end
        n_checks++; if (!ok || n != NC) $display("FAIL det_steps: got ok=%0d steps=%0d want 1/%0d", ok, n, NC); else n_pass++;
        n_checks++; if (nspk != 5 || seq_bad != 0) $display("FAIL det_alternate: got spikes=%0d misorder=%0d want 5/0", nspk, seq_bad); else n_pass++;
        tick;
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_full();
        test_patterns();
        test_net_wait();
        test_sample_toggle();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
        test_deterministic();
`endif
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter N_INPUTS, default 4: number of input spike channels.
REQ-002 Parameter PIXEL_W, default 8: intensity width per channel; N_INPUTS*PIXEL_W SHALL be <= 32.
REQ-003 Parameter N_CYCLES, default 10: time steps per presented sample.
REQ-004 Parameter CYCLES_CNT_BITWIDTH, default 5: step counter width; SHALL hold N_CYCLES.
REQ-005 Parameter LFSR_SEED, default 32'hACE1_2468: non-zero LFSR reset value.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 pix_valid  in  1  intensity vector offered.
REQ-009 pix_data  in  N_INPUTS*PIXEL_W  intensities; channel i at [i*PIXEL_W +: PIXEL_W].
REQ-010 pix_ready  out  1  encoder accepts a new vector.
REQ-011 net_ready  in  1  network ready for a new sample.
REQ-012 start  out  1  one-cycle pulse launching network evaluation.
REQ-013 sample  in  1  network consumes the current step's spikes.
REQ-014 sample_ready  out  1  in_spikes valid for the current step.
REQ-015 in_spikes  out  N_INPUTS  spike vector to the network.
REQ-016 done  out  1  one-cycle pulse after the last step is consumed.

Function
REQ-017 FSM states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-018 IDLE: pix_ready=1; pix_valid&&pix_ready latches pix_data, clears step counter and accumulators, goes to LOAD.
REQ-019 LOAD: pix_ready=0; when net_ready=1, start=1 for exactly one cycle, go to RUN; otherwise wait indefinitely.
REQ-020 On RUN entry, step-1 spikes SHALL appear with sample_ready=1 the cycle after start.
REQ-021 In RUN, sample&&sample_ready consumes the step; the next cycle presents step k+1 spikes, sample_ready held 1, no bubble.
REQ-022 sample while sample_ready=0 SHALL be ignored, with no state change.
REQ-023 Consuming step N_CYCLES SHALL go to DONE: sample_ready=0, in_spikes=0, done=1 for one cycle, then IDLE.
REQ-024 Per-channel spike rule: spike_i = (r_i < pix_i) || (pix_i == all-ones); pix_i == 0 never spikes.
REQ-025 Random source r_i = LFSR bits [i*PIXEL_W +: PIXEL_W]; 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, advances once per generated step.
REQ-026 The LFSR SHALL NOT reseed between samples; the sequence continues across vectors.
REQ-027 pix_valid with pix_ready=0 SHALL be ignored; an upstream holding pix_valid is accepted on the next IDLE cycle.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-RUN, SHALL force IDLE, LFSR=LFSR_SEED, counters/accumulators=0.
REQ-029 Reset output values: pix_ready=0, start=0, sample_ready=0, in_spikes=0, done=0; pix_ready=1 the first cycle after release.

Configuration
REQ-030 Macro SPIKE_ENCODER_DETERMINISTIC_EN defined: replace the LFSR with a per-channel PIXEL_W-bit phase accumulator, acc_i += pix_i per step, spike_i = carry-out || (pix_i == all-ones); accumulators clear on vector accept.
REQ-031 Macro undefined: LFSR encoding per REQ-024/025; no accumulator logic synthesized.

Structure
REQ-032 Package spike_encoder_pkg SHALL hold the state enum, LFSR width, tap mask, and default seed.
REQ-033 The LFSR SHALL be sub-module spike_lfsr (enable, load-seed, 32-bit state out).

Verification
REQ-034 Reset then pix_data=32'h0000_0000, net_ready=1, sample held 1 -> start one cycle, 10 steps all in_spikes=4'h0, done one cycle.
REQ-035 pix_data=32'hFFFF_FFFF, sample held 1 -> in_spikes=4'hF on all 10 steps, sample_ready continuous, done after step 10.
REQ-036 DETERMINISTIC_EN, pix_data=32'h8080_8080 -> in_spikes alternates 0,F,0,F... (5 spike steps of 10).
REQ-037 net_ready=0 for 20 cycles after accept -> start stays 0, pix_ready 0; net_ready=1 -> start pulse next cycle.
REQ-038 sample toggled every 3rd cycle -> exactly 10 consumed steps, in_spikes stable between consumes.
REQ-039 rst_n=0 at step 5 -> next cycle all outputs at reset values; LFSR back to LFSR_SEED; a fresh vector runs 10 full steps.
